ro_heater_ctrl: RTL and testbench

- Upstream sequencer for the RO heater bank. Accepts one transmit job per valid/ready handshake: bit pattern, length, heater count, half-bit period, frame count.
- Generates the `ro_heater_start` strobe train the heater FSM steps on, so each data bit becomes two timed half-bit heating phases (bit, then ~bit).
- Holds the heater's data, length and on-count inputs stable for the whole job.
- Provides abort, status and a debug word.

---
 rtl/ro_heater_ctrl_if.sv | 24 ++
 rtl/ro_heater_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_ro_heater_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ro_heater_ctrl_if.sv
// Job-configuration handshake between the host sequencer and ro_heater_ctrl.
// The master offers a job with cfg_valid; the slave accepts it while cfg_ready is high.
interface ro_heater_ctrl_if #(
  parameter int MAX_BIT_SIZE = 256,
  parameter int HP_WIDTH     = 32
) ();
  logic                          cfg_valid;
  logic                          cfg_ready;
  logic [MAX_BIT_SIZE-1:0]       cfg_data;
  logic [$clog2(MAX_BIT_SIZE):0] cfg_len;
  logic [31:0]                   cfg_on_num;
  logic [HP_WIDTH-1:0]           cfg_half_period;
  logic [15:0]                   cfg_frames;

  modport master (
    output cfg_valid, cfg_data, cfg_len, cfg_on_num, cfg_half_period, cfg_frames,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_data, cfg_len, cfg_on_num, cfg_half_period, cfg_frames,
    output cfg_ready
  );
endinterface

// File: rtl/ro_heater_ctrl.sv
// Upstream sequencer for the RO heater bank: turns one accepted job into the timed start-strobe train.
// Optional frame statistics in ctrl_debug are built when RO_HEATER_CTRL_STATS_EN is defined.
module ro_heater_ctrl #(
  parameter int MAX_BIT_SIZE   = 256,
  parameter int HP_WIDTH       = 32,
  parameter int GUARD_CYCLES   = 4,
  parameter int MAX_RO_HEATERS = 5
) (
  input  logic                          ro_clk,
  input  logic                          rst,
  ro_heater_ctrl_if.slave               cfg,
  input  logic                          abort,
  output logic                          ro_heater_rst,
  output logic                          ro_heater_start,
  output logic [MAX_BIT_SIZE-1:0]       ro_heater_data,
  output logic [$clog2(MAX_BIT_SIZE):0] ro_heater_data_len,
  output logic [31:0]                   ro_heater_on_num,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [31:0]                   ctrl_debug
);

  localparam int                  LEN_W      = $clog2(MAX_BIT_SIZE) + 1;
  localparam logic [LEN_W-1:0]    MAX_LEN    = LEN_W'(MAX_BIT_SIZE);
  localparam logic [31:0]         MAX_ON     = 32'(MAX_RO_HEATERS);
  localparam logic [HP_WIDTH-1:0] GUARD_LOAD = HP_WIDTH'(GUARD_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LAUNCH = 4'd1,
    S_DWELL  = 4'd2,
    S_STROB1 = 4'd3,
    S_STROB2 = 4'd4,
    S_GUARD  = 4'd5,
    S_ABORT  = 4'd6
  } state_e;

  state_e                  state_q, state_d;
  logic [HP_WIDTH-1:0]     cnt_q, cnt_d;
  logic [HP_WIDTH-1:0]     hp_q, hp_d;
  logic [15:0]             half_cnt_q, half_cnt_d;
  logic [15:0]             frames_left_q, frames_left_d;
  logic [MAX_BIT_SIZE-1:0] data_q, data_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [31:0]             on_num_q, on_num_d;
  logic                    cfg_ready_q, cfg_ready_d;
  logic                    start_q, start_d;
  logic                    heater_rst_q, heater_rst_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [31:0]             debug_q, debug_d;
  logic                    accept, job_bad, half_last, abort_hit;

  assign accept    = cfg.cfg_valid && cfg_ready_q;
  assign job_bad   = (cfg.cfg_len == '0) || (cfg.cfg_len > MAX_LEN) || (cfg.cfg_frames == 16'd0) ||
                     (cfg.cfg_on_num == 32'd0) || (cfg.cfg_on_num > MAX_ON);
  assign half_last = (half_cnt_q + 16'd1) == (16'(len_q) << 1);
  // ABORT itself always drains to IDLE so the heater reset pulse stays one cycle wide.
  assign abort_hit = abort && (state_q != S_IDLE) && (state_q != S_ABORT);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    hp_d          = hp_q;
    half_cnt_d    = half_cnt_q;
    frames_left_d = frames_left_q;
    data_d        = data_q;
    len_d         = len_q;
    on_num_d      = on_num_q;
    err_d         = err_q;
    done_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d        = cfg.cfg_data;
          len_d         = cfg.cfg_len;
          on_num_d      = cfg.cfg_on_num;
          hp_d          = (cfg.cfg_half_period == '0) ? HP_WIDTH'(1) : cfg.cfg_half_period;
          frames_left_d = cfg.cfg_frames;
          err_d         = job_bad;
          if (job_bad) done_d  = 1'b1;
          else         state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        half_cnt_d = 16'd0;
        cnt_d      = hp_q - HP_WIDTH'(1);
        state_d    = S_DWELL;
      end
      S_DWELL: begin
        if (cnt_q == '0) state_d = S_STROB1;
        else             cnt_d   = cnt_q - HP_WIDTH'(1);
      end
      S_STROB1: state_d = S_STROB2;
      S_STROB2: begin
        half_cnt_d = half_cnt_q + 16'd1;
        if (half_last) begin
          state_d = S_GUARD;
          cnt_d   = GUARD_LOAD;
        end else begin
          state_d = S_DWELL;
          cnt_d   = hp_q - HP_WIDTH'(1);
        end
      end
      S_GUARD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - HP_WIDTH'(1);
        end else if (frames_left_q > 16'd1) begin
          frames_left_d = frames_left_q - 16'd1;
          state_d       = S_LAUNCH;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_ABORT: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_hit) begin
      state_d = S_ABORT;
      done_d  = 1'b0;
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    cfg_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    start_d      = (state_d == S_LAUNCH) || (state_d == S_STROB1) || (state_d == S_STROB2);
    heater_rst_d = (state_d == S_ABORT);
  end

`ifdef RO_HEATER_CTRL_STATS_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q == S_GUARD && cnt_q == '0 && !abort && frame_cnt_q != '1)
      frame_cnt_d = frame_cnt_q + 32'd1;
  end

  always_ff @(posedge ro_clk) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign debug_d = frame_cnt_d;
`else
  assign debug_d = {state_d, frames_left_d[11:0], half_cnt_d};
`endif

  // NOTE: state updates use <= so every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge ro_clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      hp_q          <= '0;
      half_cnt_q    <= '0;
      frames_left_q <= '0;
      // NOTE: the wide pattern register is cleared too, because the heater sees it directly.
      data_q        <= '0;
      len_q         <= '0;
      on_num_q      <= '0;
      cfg_ready_q   <= 1'b1;
      start_q       <= 1'b0;
      heater_rst_q  <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      debug_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hp_q          <= hp_d;
      half_cnt_q    <= half_cnt_d;
      frames_left_q <= frames_left_d;
      data_q        <= data_d;
      len_q         <= len_d;
      on_num_q      <= on_num_d;
      cfg_ready_q   <= cfg_ready_d;
      start_q       <= start_d;
      heater_rst_q  <= heater_rst_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      debug_q       <= debug_d;
    end
  end

  assign cfg.cfg_ready        = cfg_ready_q;
  assign ro_heater_rst        = heater_rst_q;
  assign ro_heater_start      = start_q;
  assign ro_heater_data       = data_q;
  assign ro_heater_data_len   = len_q;
  assign ro_heater_on_num     = on_num_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign err                  = err_q;
  assign ctrl_debug           = debug_q;

endmodule

// File: tb/tb_ro_heater_ctrl.sv
// Self-checking bench for ro_heater_ctrl: directed scenarios plus randomized jobs checked
// cycle by cycle against an arithmetic model of the strobe schedule.
module tb_ro_heater_ctrl;

  localparam int MAXB  = 256;
  localparam int HPW   = 32;
  localparam int GUARD = 4;
  localparam int MAXH  = 5;
  localparam int LW    = $clog2(MAXB) + 1;

  logic            ro_clk = 1'b0;
  logic            rst    = 1'b1;
  logic            abort  = 1'b0;
  logic            ro_heater_rst, ro_heater_start, busy, done, err;
  logic [MAXB-1:0] ro_heater_data;
  logic [LW-1:0]   ro_heater_data_len;
  logic [31:0]     ro_heater_on_num, ctrl_debug;

  int n_checks          = 0;
  int n_errors          = 0;
  int frames_done_total = 0;

  ro_heater_ctrl_if #(.MAX_BIT_SIZE(MAXB), .HP_WIDTH(HPW)) cfg_if ();

  ro_heater_ctrl #(
    .MAX_BIT_SIZE  (MAXB),
    .HP_WIDTH      (HPW),
    .GUARD_CYCLES  (GUARD),
    .MAX_RO_HEATERS(MAXH)
  ) u_dut (
    .ro_clk            (ro_clk),
    .rst               (rst),
    .cfg               (cfg_if),
    .abort             (abort),
    .ro_heater_rst     (ro_heater_rst),
    .ro_heater_start   (ro_heater_start),
    .ro_heater_data    (ro_heater_data),
    .ro_heater_data_len(ro_heater_data_len),
    .ro_heater_on_num  (ro_heater_on_num),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .ctrl_debug        (ctrl_debug)
  );

  always #5 ro_clk = ~ro_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  // Start is high on the launch cycle (offset 0) and on the last two cycles of every
  // (hp + 2)-cycle half-bit slot; the guard tail is low.
  function automatic bit model_start(int o, int len, int hpe);
    if (o == 0) return 1'b1;
    if (o > 2 * len * (hpe + 2)) return 1'b0;
    return ((o - 1) % (hpe + 2)) >= hpe;
  endfunction

  function automatic logic [MAXB-1:0] rand_data();
    logic [MAXB-1:0] d;
    for (int i = 0; i < MAXB / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Offers one job at the current negedge and checks every following cycle against the model.
  // abort_at > 0 asserts abort during cycle T+abort_at (T = offer cycle).
  task automatic run_job(input string name, input int len, input logic [MAXB-1:0] data,
                         input int on_num, input int hp, input int frames,
                         input int abort_at, input bit abort_with_valid);
    int hpe, fl, total, last_k, waited;
    bit bad;
    logic [4:0] obs, expv, mask;
    hpe    = (hp == 0) ? 1 : hp;
    bad    = (len == 0) || (len > MAXB) || (frames == 0) || (on_num < 1) || (on_num > MAXH);
    fl     = 1 + 2 * len * (hpe + 2) + GUARD;
    total  = frames * fl;
    last_k = bad ? 1 : ((abort_at > 0) ? abort_at + 2 : total + 1);

    waited = 0;
    while (cfg_if.cfg_ready !== 1'b1 && waited < 50) begin
      @(negedge ro_clk);
      waited++;
    end
    n_checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s ready_timeout: cfg_ready=%b, required 1", name, cfg_if.cfg_ready);
      return;
    end

    cfg_if.cfg_valid       = 1'b1;
    cfg_if.cfg_data        = data;
    cfg_if.cfg_len         = LW'(len);
    cfg_if.cfg_on_num      = 32'(on_num);
    cfg_if.cfg_half_period = HPW'(hp);
    cfg_if.cfg_frames      = 16'(frames);
    abort                  = abort_with_valid;

    for (int k = 1; k <= last_k + 1; k++) begin
      @(negedge ro_clk);
      cfg_if.cfg_valid = 1'b0;
      abort            = 1'b0;
      mask             = 5'b11111;
      // Bit order: {start, busy, done, cfg_ready, ro_heater_rst}
      if (bad)                                   expv = (k == 1) ? 5'b00110 : 5'b00010;
      else if (abort_at > 0 && k == abort_at + 1) begin expv = 5'b00001; mask = 5'b10111; end
      else if (k >= last_k)                      expv = (k == last_k) ? 5'b00110 : 5'b00010;
      else                                       expv = {model_start((k - 1) % fl, len, hpe), 4'b1000};
      obs = {ro_heater_start, busy, done, cfg_if.cfg_ready, ro_heater_rst};
      n_checks++;
      if ((obs & mask) !== (expv & mask)) begin
        n_errors++;
        $display("FAIL %s outputs at T+%0d: {start,busy,done,ready,hrst}=%b, required %b (mask %b)",
                 name, k, obs, expv, mask);
      end

      if (k == 1) begin
        n_checks++;
        if (ro_heater_data !== data || ro_heater_data_len !== LW'(len) ||
            ro_heater_on_num !== 32'(on_num)) begin
          n_errors++;
          $display("FAIL %s latched: len=%0d on_num=%0d data_ok=%b, required len=%0d on_num=%0d",
                   name, ro_heater_data_len, ro_heater_on_num, ro_heater_data === data, len, on_num);
        end
      end

      if (k >= last_k) begin
        n_checks++;
        if (err !== bad) begin
          n_errors++;
          $display("FAIL %s err at T+%0d: err=%b, required %b", name, k, err, bad);
        end
      end

      if (k == last_k) begin
        n_checks++;
        if (ro_heater_on_num !== 32'(on_num) || ro_heater_data_len !== LW'(len)) begin
          n_errors++;
          $display("FAIL %s latched_hold: on_num=%0d len=%0d, required %0d %0d",
                   name, ro_heater_on_num, ro_heater_data_len, on_num, len);
        end
`ifdef RO_HEATER_CTRL_STATS_EN
        if (!bad) frames_done_total += (abort_at > 0) ? (abort_at - 1) / fl : frames;
        n_checks++;
        if (ctrl_debug !== 32'(frames_done_total)) begin
          n_errors++;
          $display("FAIL %s frame_count: got %0d, required %0d", name, ctrl_debug, frames_done_total);
        end
`else
        if (!bad && abort_at <= 0) begin
          n_checks++;
          if (ctrl_debug[27:0] !== {12'd1, 16'(2 * len)}) begin
            n_errors++;
            $display("FAIL %s debug: frames_left=%0d half_cnt=%0d, required 1 %0d",
                     name, ctrl_debug[27:16], ctrl_debug[15:0], 2 * len);
          end
        end
`endif
      end

      if (abort_at > 0 && k == abort_at) abort = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge ro_clk);
    n_checks++;
    if ({cfg_if.cfg_ready, ro_heater_rst, ro_heater_start, busy, done, err} !== 6'b110000) begin
      n_errors++;
      $display("FAIL reset_outputs: {ready,hrst,start,busy,done,err}=%b, required 110000",
               {cfg_if.cfg_ready, ro_heater_rst, ro_heater_start, busy, done, err});
    end
    n_checks++;
    if (ctrl_debug !== 32'd0 || ro_heater_data !== '0 || ro_heater_data_len !== '0 ||
        ro_heater_on_num !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_latched: debug=%h len=%0d on_num=%0d, required all zero",
               ctrl_debug, ro_heater_data_len, ro_heater_on_num);
    end
    rst = 1'b0;
    @(negedge ro_clk);
    n_checks++;
    if (ro_heater_rst !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release: hrst=%b ready=%b, required 0 1", ro_heater_rst, cfg_if.cfg_ready);
    end
  endtask

  task automatic test_basic();
    logic [MAXB-1:0] d;
    d = '0;
    d[1:0] = 2'b10;
    run_job("basic", 2, d, 3, 4, 1, 0, 1'b0);
  endtask

  task automatic test_repeats();
    run_job("repeats", 1, rand_data(), 2, 1, 3, 0, 1'b0);
  endtask

  task automatic test_reject();
    run_job("reject_on0",     2, rand_data(), 0, 2, 1, 0, 1'b0);
    run_job("reject_len0",    0, rand_data(), 2, 2, 1, 0, 1'b0);
    run_job("reject_frames0", 2, rand_data(), 2, 2, 0, 0, 1'b0);
    run_job("after_reject",   2, rand_data(), 5, 1, 1, 0, 1'b0);
  endtask

  task automatic test_abort();
    // hp=3: second dwell spans T+7..T+9
    run_job("abort_dwell2", 4, rand_data(), 1, 3, 1, 8, 1'b0);
    run_job("after_abort",  2, rand_data(), 4, 2, 1, 0, 1'b0);
  endtask

  task automatic test_edge();
    run_job("hp_zero",          3,    rand_data(), 2, 0, 2, 0, 1'b0);
    run_job("len_max",          MAXB, rand_data(), 5, 1, 1, 0, 1'b0);
    run_job("valid_with_abort", 3,    rand_data(), 2, 2, 1, 0, 1'b1);
  endtask

  task automatic test_random();
    int len, hp, frames, on_num, abort_at, fl, r;
    for (int i = 0; i < 14; i++) begin
      len      = $urandom_range(1, 6);
      hp       = $urandom_range(0, 4);
      frames   = $urandom_range(1, 3);
      on_num   = $urandom_range(1, MAXH);
      abort_at = 0;
      r        = $urandom_range(0, 9);
      if (r == 0)      on_num = $urandom_range(MAXH + 1, 40);
      else if (r == 1) len    = $urandom_range(MAXB + 1, 400);
      else if (r == 2) frames = 0;
      else if (r >= 7) begin
        fl       = 1 + 2 * len * (((hp == 0) ? 1 : hp) + 2) + GUARD;
        abort_at = $urandom_range(1, frames * fl);
      end
      run_job($sformatf("random%0d", i), len, rand_data(), on_num, hp, frames, abort_at, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge ro_clk);
    end
  endtask

  initial begin
    cfg_if.cfg_valid       = 1'b0;
    cfg_if.cfg_data        = '0;
    cfg_if.cfg_len         = '0;
    cfg_if.cfg_on_num      = '0;
    cfg_if.cfg_half_period = '0;
    cfg_if.cfg_frames      = '0;
    test_reset();
    test_basic();
    test_repeats();
    test_reject();
    test_abort();
    test_edge();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
